// File: rtl/muldiv_issue_ctrl.sv
// Issue/writeback controller in front of the MULDIV unit: holds operands, pulses start
// for divisions, waits out busy (with watchdog), and returns the result with rd.
module muldiv_issue_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstLow,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [2:0]       req_funct3,
  input  logic [4:0]       req_rd,
  input  logic             flush,
  output logic [31:0]      md_rs1,
  output logic [31:0]      md_rs2,
  output logic [2:0]       md_funct3,
  output logic             md_start,
  input  logic             md_busy,
  input  logic [31:0]      md_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_err,
  output logic [CNT_W-1:0] op_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_DRAIN} state_e;

  localparam int                WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [31:0]      rs1_q, rs2_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             wb_err_q, wb_err_d;
  logic [CNT_W-1:0] op_cycles_q, op_cycles_d;
  logic             accept;

  assign accept  = (state_q == S_IDLE) && req_valid;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      state_q     <= S_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      wb_data_q   <= '0;
      wb_err_q    <= 1'b0;
      op_cycles_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      wb_data_q   <= wb_data_d;
      wb_err_q    <= wb_err_d;
      op_cycles_q <= op_cycles_d;
      if (accept) begin
        rs1_q    <= req_rs1;
        rs2_q    <= req_rs2;
        funct3_q <= req_funct3;
        rd_q     <= req_rd;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    wb_data_d   = wb_data_q;
    wb_err_d    = wb_err_q;
    op_cycles_d = op_cycles_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        cnt_d   = CNT_ONE;
        wd_d    = '0;
        state_d = flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // A flush while the divider is still iterating must let it finish before reissue.
        if (flush) begin
          state_d = md_busy ? S_DRAIN : S_IDLE;
        end else if (!md_busy) begin
          wb_data_d   = md_result;
          wb_err_d    = 1'b0;
          op_cycles_d = cnt_inc;
          state_d     = S_DONE;
        end else if (wd_q == WD_LAST) begin
          wb_data_d = '0;
          wb_err_d  = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE: begin
        if (flush || wb_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (!md_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign md_start  = (state_q == S_LAUNCH) && funct3_q[2];
  assign md_rs1    = rs1_q;
  assign md_rs2    = rs2_q;
  assign md_funct3 = funct3_q;
  assign wb_valid  = (state_q == S_DONE);
  assign wb_data   = wb_data_q;
  assign wb_rd     = rd_q;
  assign wb_err    = wb_err_q;
  assign op_cycles = op_cycles_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl with a small behavioural MULDIV model.
module tb_muldiv_issue_ctrl;

  logic        clk;
  logic        rstLow;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_rs1, req_rs2;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        flush;
  logic [31:0] md_rs1, md_rs2;
  logic [2:0]  md_funct3;
  logic        md_start;
  logic        md_busy;
  logic [31:0] md_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_err;
  logic [7:0]  op_cycles;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int busy_seen = 0;
  int wbv_seen = 0;
  int busy_len = 4;
  int busy_cnt;
  logic        c_vld;
  logic [31:0] c_a, c_b;
  logic        c_s;

  muldiv_issue_ctrl #(.TIMEOUT_CYC(64), .CNT_W(8)) dut (
    .clk(clk), .rstLow(rstLow),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3), .req_rd(req_rd),
    .flush(flush),
    .md_rs1(md_rs1), .md_rs2(md_rs2), .md_funct3(md_funct3), .md_start(md_start),
    .md_busy(md_busy), .md_result(md_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_err(wb_err), .op_cycles(op_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdiv(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [63:0]        pu;
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    pu  = {32'b0, a} * {32'b0, b};
    case (f)
      3'd0: return pu[31:0];
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : sa / sb;
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : sa % sb;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // MULDIV model: divisions iterate busy_len cycles unless special-case or same operands as last.
  logic model_special, model_hit;
  assign model_special = (md_rs2 == 0) || (!md_funct3[0] && md_rs1 == 32'h8000_0000 && md_rs2 == 32'hFFFF_FFFF);
  assign model_hit     = c_vld && (c_a == md_rs1) && (c_b == md_rs2) && (c_s == ~md_funct3[0]);
  assign md_busy       = (busy_cnt > 0);
  assign md_result     = md_busy ? 32'hDEAD_BEEF : mdiv(md_funct3, md_rs1, md_rs2);

  always @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      busy_cnt <= 0;
      c_vld    <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_s      <= 1'b0;
    end else if (md_start) begin
      if (!model_special && !model_hit) busy_cnt <= busy_len;
      c_vld <= 1'b1;
      c_a   <= md_rs1;
      c_b   <= md_rs2;
      c_s   <= ~md_funct3[0];
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (md_start === 1'b1) start_cnt++;
    if (md_busy === 1'b1)  busy_seen++;
    if (wb_valid === 1'b1) wbv_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle, then waits for wb_valid; lat counts the request cycle as 0.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, output int lat);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_funct3 = f;
    req_rs1    = a;
    req_rs2    = b;
    req_rd     = rd;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!wb_valid && lat < 300) begin
      step();
      lat++;
    end
  endtask

  task automatic wb_accept(input string tag);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk({tag, "_wb_drop"}, {31'b0, wb_valid}, 32'd0);
    chk({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int n;
    int s0;
    rstLow = 1'b0; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_funct3 = '0; req_rd = '0;
    flush = 1'b0; wb_ready = 1'b0;
    repeat (3) step();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_md_start", {31'b0, md_start}, 32'd0);
    chk("rst_md_rs1", md_rs1, 32'd0);
    chk("rst_md_rs2", md_rs2, 32'd0);
    chk("rst_md_funct3", {29'b0, md_funct3}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    chk("rst_wb_err", {31'b0, wb_err}, 32'd0);
    chk("rst_op_cycles", {24'b0, op_cycles}, 32'd0);
    rstLow = 1'b1;
    step();

    // MUL 7 * -3
    wb_ready = 1'b1;
    start_cnt = 0;
    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat);
    chk("mul_lat", lat, 32'd3);
    chk("mul_data", wb_data, 32'hFFFF_FFEB);
    chk("mul_rd", {27'b0, wb_rd}, 32'd5);
    chk("mul_err", {31'b0, wb_err}, 32'd0);
    chk("mul_opcyc", {24'b0, op_cycles}, 32'd2);
    chk("mul_nostart", start_cnt, 32'd0);
    wb_accept("mul");

    // DIV 100/7 with 4 busy cycles, then REM on identical operands
    busy_len = 4;
    busy_seen = 0;
    run_op("div", 3'b100, 32'd100, 32'd7, 5'd9, lat);
    chk("div_lat", lat, 32'd7);
    chk("div_data", wb_data, 32'd14);
    chk("div_busy", busy_seen, 32'd4);
    chk("div_opcyc", {24'b0, op_cycles}, 32'd6);
    wb_accept("div");
    busy_seen = 0;
    s0 = start_cnt;
    run_op("rem", 3'b110, 32'd100, 32'd7, 5'd10, lat);
    chk("rem_lat", lat, 32'd3);
    chk("rem_data", wb_data, 32'd2);
    chk("rem_nobusy", busy_seen, 32'd0);
    chk("rem_start", start_cnt - s0, 32'd1);
    chk("rem_rd", {27'b0, wb_rd}, 32'd10);
    wb_accept("rem");

    // DIVU by zero
    busy_seen = 0;
    s0 = start_cnt;
    run_op("divu0", 3'b101, 32'd1234, 32'd0, 5'd3, lat);
    chk("divu0_lat", lat, 32'd3);
    chk("divu0_data", wb_data, 32'hFFFF_FFFF);
    chk("divu0_start", start_cnt - s0, 32'd1);
    chk("divu0_nobusy", busy_seen, 32'd0);
    wb_accept("divu0");

    // DIV 1000/3 held under writeback backpressure
    busy_len = 3;
    run_op("bp", 3'b100, 32'd1000, 32'd3, 5'd17, lat);
    chk("bp_lat", lat, 32'd6);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, wb_valid}, 32'd1);
      chk("bp_data", wb_data, 32'd333);
      chk("bp_rd", {27'b0, wb_rd}, 32'd17);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      step();
    end
    wb_accept("bp");

    // Flush two cycles into a DIV busy period
    busy_len = 6;
    wb_ready = 1'b1;
    wbv_seen = 0;
    req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'd50; req_rs2 = 32'd5; req_rd = 5'd4;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("fl_busy", {31'b0, md_busy}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk("fl_drain_cycles", n, 32'd5);
    chk("fl_busy_done", {31'b0, md_busy}, 32'd0);
    chk("fl_no_wb", wbv_seen, 32'd0);
    chk("fl_md_rs1_held", md_rs1, 32'd50);
    wb_ready = 1'b0;
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, lat);
    chk("mulhu_lat", lat, 32'd3);
    chk("mulhu_data", wb_data, 32'hFFFF_FFFE);
    wb_accept("mulhu");

    // Divider stuck busy -> watchdog
    busy_len = 200;
    run_op("to", 3'b100, 32'd9, 32'd2, 5'd8, lat);
    chk("to_lat", lat, 32'd66);
    chk("to_err", {31'b0, wb_err}, 32'd1);
    chk("to_data", wb_data, 32'd0);
    chk("to_opcyc_kept", {24'b0, op_cycles}, 32'd2);
    wb_accept("to");

    // Asynchronous reset in the middle of WAIT
    req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'd9; req_rs2 = 32'd4; req_rd = 5'd12;
    step();
    req_valid = 1'b0;
    repeat (10) step();
    chk("mid_busy", {31'b0, md_busy}, 32'd1);
    #2;
    rstLow = 1'b0;
    #1;
    chk("ar_req_ready", {31'b0, req_ready}, 32'd1);
    chk("ar_md_rs1", md_rs1, 32'd0);
    chk("ar_md_rs2", md_rs2, 32'd0);
    chk("ar_md_funct3", {29'b0, md_funct3}, 32'd0);
    chk("ar_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("ar_wb_rd", {27'b0, wb_rd}, 32'd0);
    chk("ar_wb_err", {31'b0, wb_err}, 32'd0);
    chk("ar_op_cycles", {24'b0, op_cycles}, 32'd0);
    step();
    step();
    rstLow = 1'b1;
    wbv_seen = 0;
    repeat (5) step();
    chk("ar_no_wb", wbv_seen, 32'd0);
    chk("ar_idle", {31'b0, req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Issue/writeback controller directly upstream of the M-extension MULDIV unit.
- Accepts one request at a time from the core execute stage over a valid/ready handshake and holds operands stable on the MULDIV inputs.
- Pulses start for divisions, waits on busy, captures the result and returns it with rd to writeback over a valid/ready handshake.
- Also handles flush, a watchdog timeout and a per-operation cycle count.

Parameters:
- TIMEOUT_CYC, 64: max WAIT cycles with md_busy high before abort.
- CNT_W, 8: width of op_cycles counter.

Ports:
- clk  in  1  clock
- rstLow  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept request
- req_rs1  in  32  operand rs1
- req_rs2  in  32  operand rs2
- req_funct3  in  3  M-extension funct3 (000 MUL .. 111 REMU)
- req_rd  in  5  destination register
- flush  in  1  abort in-flight op, discard result
- md_rs1  out  32  to MULDIV rs1
- md_rs2  out  32  to MULDIV rs2
- md_funct3  out  3  to MULDIV funct3
- md_start  out  1  to MULDIV start
- md_busy  in  1  from MULDIV busy
- md_result  in  32  from MULDIV c_out
- wb_valid  out  1  result valid
- wb_ready  in  1  writeback accepts
- wb_data  out  32  result
- wb_rd  out  5  destination register
- wb_err  out  1  result aborted by timeout (wb_data=0)
- op_cycles  out  CNT_W  cycles of last completed op, saturating

Behaviour:
- Reset: clk, rstLow asynchronous active-low. All registers clear. State=IDLE, req_ready=1, md_start=0, md_rs1/md_rs2/md_funct3=0, wb_valid=0, wb_data=0, wb_rd=0, wb_err=0, op_cycles=0.
- Reset mid-operation: return to IDLE at once; no wb_valid is produced.
- MULDIV contract: MUL-class results (funct3[2]=0) and division special cases are valid combinationally in the start cycle. A launched division raises md_busy in the cycle after md_start and holds it until md_result is valid.
- md_rs1, md_rs2 and md_funct3 are registered at accept and held unchanged until the next accept.
- IDLE: req_ready=1. On req_valid at an edge, latch operands, funct3 and rd; go to LAUNCH.
- LAUNCH (1 cycle): md_start=funct3[2]; cycle counter=1; go to WAIT.
- WAIT: counter increments each cycle.
  - md_busy=0: capture md_result into wb_data, wb_err=0, op_cycles=counter; go to DONE.
  - md_busy=1 for TIMEOUT_CYC consecutive cycles: wb_data=0, wb_err=1; go to DONE.
- DONE: wb_valid=1; wb_data, wb_rd and wb_err are stable while wb_ready=0. On wb_ready, go to IDLE and drop wb_valid next cycle. No new request is accepted in the same cycle (req_ready=0 outside IDLE).
- Latency: accept edge cycle 0, LAUNCH cycle 1, WAIT cycle 2, wb_valid cycle 3 at minimum. A division with N busy cycles has wb_valid at cycle 3+N.
- Flush:
  - In LAUNCH, or WAIT with md_busy=0: go to IDLE, no wb_valid.
  - In WAIT with md_busy=1: go to DRAIN, which holds md_* stable and returns to IDLE when md_busy=0, discarding the result.
  - In DONE: wb_valid drops, go to IDLE.
  - In IDLE: no effect.
- Flush and wb_ready in the same DONE cycle: flush wins. Flush has priority over timeout.
- op_cycles saturates at 2^CNT_W-1 and updates only on a non-timeout completion.
- Back-to-back DIV then REM with identical operands: md_* stay equal, so MULDIV returns REM without busy (latency 3).

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, rd=5, wb_ready=1 -> wb_valid 3 cycles after accept, wb_data=0xFFFFFFEB, wb_rd=5, md_start never 1, op_cycles=2.
- DIV 100/7 then REM 100/7 -> first wb_data=14 with md_busy high >=1 cycle; second wb_data=2 with md_busy never high and latency 3.
- DIVU rs2=0 -> md_start pulses, md_busy stays 0, wb_data=0xFFFFFFFF, latency 3.
- DIV 1000/3 with wb_ready=0 for 5 cycles -> wb_valid, wb_data=333 and wb_rd held stable; req_ready=0 throughout; IDLE one cycle after wb_ready.
- Flush 2 cycles into a DIV busy period -> no wb_valid; req_ready returns only after md_busy falls; a following MULHU 0xFFFFFFFF*0xFFFFFFFF returns 0xFFFFFFFE.
- Model busy stuck high, TIMEOUT_CYC=64 -> wb_valid with wb_err=1, wb_data=0 after 64 WAIT cycles. Then rstLow low mid-WAIT -> all outputs 0 immediately.
